// File: rtl/glb_read_streamer.sv
// Read-side master for the global buffer: issues strided reads for one configured
// transfer and re-emits the returned words as a valid/ready stream through a small FIFO.
module glb_read_streamer #(
  parameter int dataSize  = 8,
  parameter int depth     = 1024,
  parameter int fifoDepth = 4,
  parameter int addrWidth = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [addrWidth-1:0] cfgBase,
  input  logic [addrWidth:0]   cfgCount,
  input  logic [addrWidth-1:0] cfgStride,
  output logic                 busy,
  output logic                 done,
  output logic [addrWidth-1:0] readAddr,
  output logic                 readEn,
  input  logic [dataSize-1:0]  readData,
  output logic [dataSize-1:0]  outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [1:0]           dbgState
);

  localparam int PW = (fifoDepth > 1) ? $clog2(fifoDepth) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] OCC_LIMIT = (CW+1)'(fifoDepth);

  // Handshake: an element moves downstream on a cycle where outValid && outReady;
  // outValid never drops and outData never changes until that happens.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [addrWidth-1:0]  r_cur_addr;
  logic [addrWidth-1:0]  r_stride;
  logic [addrWidth-1:0]  r_last_addr;
  logic [addrWidth:0]    r_remaining;
  logic                  r_in_flight;
  logic [dataSize-1:0]   r_mem [fifoDepth];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic                  w_issue;
  logic                  w_load;
  logic                  w_done;
  logic                  w_push;
  logic                  w_pop;
  logic [CW:0]           w_occ;

  // A read is only issued when the FIFO has room for it and the word still in flight.
  assign w_occ  = {1'b0, r_count} + {{CW{1'b0}}, r_in_flight};
  assign w_push = r_in_flight;
  assign w_pop  = outValid && outReady;

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    w_load       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_next_state = (cfgCount == '0) ? DRAIN : RUN;
        end
      end
      RUN: begin
        if ((r_remaining != '0) && (w_occ < OCC_LIMIT)) begin
          w_issue = 1'b1;
          if (r_remaining == (addrWidth+1)'(1)) w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (!r_in_flight && ((r_count == '0) || ((r_count == CW'(1)) && w_pop))) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_stride    <= '0;
      r_last_addr <= '0;
      r_remaining <= '0;
      r_in_flight <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_in_flight <= w_issue;
      if (w_load) begin
        r_cur_addr  <= cfgBase;
        r_remaining <= cfgCount;
        r_stride    <= cfgStride;
      end else if (w_issue) begin
        r_cur_addr  <= r_cur_addr + r_stride;
        r_remaining <= r_remaining - (addrWidth+1)'(1);
        r_last_addr <= r_cur_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= readData;
  end

  assign readEn   = w_issue;
  assign readAddr = w_issue ? r_cur_addr : r_last_addr;
  assign outValid = (r_count != '0);
  assign outData  = outValid ? r_mem[r_rd_ptr] : '0;
  assign busy     = (r_state != IDLE);
  assign done     = w_done;
  assign dbgState = r_state;

endmodule
